// File: rtl/i2c_pkg.sv
// Shared I2C definitions: address width, ACK encoding and the target receiver state enum.
`default_nettype none

package i2c_pkg;

  localparam int   I2C_ADDR_WIDTH = 7;
  localparam logic I2C_ACK        = 1'b0;
  localparam logic I2C_NACK       = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_DATA      = 3'd3,
    ST_DATA_ACK  = 3'd4,
    ST_WAIT_STOP = 3'd5
  } i2c_slave_state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_sync.sv
// Flop-chain synchroniser for an asynchronous bus line; resets to the idle-high level.
`default_nettype none

module i2c_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/i2c_slave_rx.sv
// I2C target write receiver: detects START/STOP, ACKs its own write address and
// streams each received data byte out on a valid/ready interface.
`default_nettype none

module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = I2C_ADDR_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  a_rst_n_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] self_addr_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  sda_t,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  addr_hit_o,
  output logic                  overflow_o
);

  localparam int SHIFT_W = (DATA_WIDTH > ADDR_WIDTH + 1) ? DATA_WIDTH : ADDR_WIDTH + 1;
  localparam logic [3:0] CNT_MAX   = 4'(SHIFT_W);
  localparam logic [3:0] ADDR_LAST = 4'(ADDR_WIDTH);
  localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);

  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, bus_start, bus_stop;

  i2c_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk_i),
    .rst_n (a_rst_n_i),
    .d     (scl_i),
    .q     (scl_s)
  );

  i2c_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk_i),
    .rst_n (a_rst_n_i),
    .d     (sda_i),
    .q     (sda_s)
  );

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign bus_start =  scl_s &  scl_d &  sda_d & ~sda_s;
  assign bus_stop  =  scl_s &  scl_d & ~sda_d &  sda_s;

  i2c_slave_state_t      state, state_nxt;
  logic [3:0]            cnt, cnt_nxt, cnt_inc;
  logic [SHIFT_W-1:0]    shift, shift_nxt, w_byte;
  logic                  sda_t_nxt;
  logic                  ack_arm, ack_arm_nxt;
  logic                  ack_drv, ack_drv_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  valid_nxt, hit_nxt, ovf_nxt;

  assign w_byte  = {shift[SHIFT_W-2:0], sda_s};
  assign cnt_inc = (cnt < CNT_MAX) ? cnt + 4'd1 : cnt;

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shift      <= '0;
      sda_t      <= 1'b1;
      ack_arm    <= 1'b0;
      ack_drv    <= 1'b0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      addr_hit_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shift      <= shift_nxt;
      sda_t      <= sda_t_nxt;
      ack_arm    <= ack_arm_nxt;
      ack_drv    <= ack_drv_nxt;
      data_o     <= data_nxt;
      valid_o    <= valid_nxt;
      addr_hit_o <= hit_nxt;
      overflow_o <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shift_nxt   = shift;
    sda_t_nxt   = sda_t;
    ack_arm_nxt = ack_arm;
    ack_drv_nxt = ack_drv;
    data_nxt    = data_o;
    valid_nxt   = valid_o;
    hit_nxt     = 1'b0;
    ovf_nxt     = 1'b0;

    // The output stream is independent of bus events: a held byte survives START/STOP/disable.
    if (valid_o && ready_i) valid_nxt = 1'b0;

    if (!en_i || bus_stop) begin
      state_nxt   = ST_IDLE;
      sda_t_nxt   = 1'b1;
      ack_arm_nxt = 1'b0;
    end else if (bus_start) begin
      state_nxt   = ST_ADDR;
      cnt_nxt     = '0;
      sda_t_nxt   = 1'b1;
      ack_arm_nxt = 1'b0;
    end else begin
      unique case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_nxt = w_byte;
            cnt_nxt   = cnt_inc;
            if (cnt == ADDR_LAST) begin
              if (w_byte[ADDR_WIDTH:1] == self_addr_i && !w_byte[0]) begin
                state_nxt   = ST_ADDR_ACK;
                ack_drv_nxt = 1'b1;
                hit_nxt     = 1'b1;
              end else begin
                state_nxt = ST_WAIT_STOP;
              end
            end
          end
        end

        ST_DATA: begin
          if (scl_rise) begin
            shift_nxt = w_byte;
            cnt_nxt   = cnt_inc;
            if (cnt == DATA_LAST) begin
              state_nxt = ST_DATA_ACK;
              if (!valid_o) begin
                data_nxt    = w_byte[DATA_WIDTH-1:0];
                valid_nxt   = 1'b1;
                ack_drv_nxt = 1'b1;
              end else begin
                ovf_nxt     = 1'b1;
                ack_drv_nxt = 1'b0;
              end
            end
          end
        end

        // First SCL fall opens the ACK slot, the second one closes it.
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_arm) begin
              ack_arm_nxt = 1'b1;
              sda_t_nxt   = ack_drv ? I2C_ACK : I2C_NACK;
            end else begin
              ack_arm_nxt = 1'b0;
              sda_t_nxt   = 1'b1;
              cnt_nxt     = '0;
              state_nxt   = ST_DATA;
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign sda_o  = 1'b0;
  assign busy_o = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
// Directed bench: an I2C master model drives the wires; results checked against hand-computed values.
`default_nettype none

module tb_i2c_slave_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [6:0] self_addr;
  logic       scl;
  logic       sda_m;
  wire        sda_bus;
  logic       sda_o, sda_t;
  logic [7:0] data;
  logic       valid, ready, busy, addr_hit, overflow;

  int total = 0;
  int bad   = 0;
  int drive_cnt = 0, hit_cnt = 0, ovf_cnt = 0, acc_cnt = 0;
  logic [7:0] last_data = 8'h00;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & (sda_t ? 1'b1 : sda_o);

  i2c_slave_rx #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .a_rst_n_i   (rst_n),
    .en_i        (en),
    .self_addr_i (self_addr),
    .scl_i       (scl),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .sda_t       (sda_t),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .busy_o      (busy),
    .addr_hit_o  (addr_hit),
    .overflow_o  (overflow)
  );

  always @(negedge clk) begin
    if (sda_t == 1'b0) drive_cnt++;
    if (addr_hit) hit_cnt++;
    if (overflow) ovf_cnt++;
    if (valid && ready) begin
      acc_cnt++;
      last_data = data;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl = 1'b1; wait_clk(8);
    sda_m = 1'b0; wait_clk(8);
    scl = 1'b0;   wait_clk(4);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; wait_clk(4);
    scl = 1'b1;   wait_clk(8);
    sda_m = 1'b0; wait_clk(8);
    scl = 1'b0;   wait_clk(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(4);
    scl = 1'b1;   wait_clk(8);
    sda_m = 1'b1; wait_clk(8);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;  wait_clk(4);
    scl = 1'b1; wait_clk(8);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_clk(4);
    scl = 1'b1;   wait_clk(4);
    ack = sda_bus;
    wait_clk(4);
    scl = 1'b0;   wait_clk(4);
  endtask

  initial begin
    logic ack;
    int   d_hit, d_drv, d_acc, d_ovf;

    rst_n = 1'b0; en = 1'b1; self_addr = 7'h50; ready = 1'b1;
    scl = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    check_val("rst_sda_t", 32'(sda_t), 32'd1);
    check_val("rst_sda_o", 32'(sda_o), 32'd0);
    check_val("rst_data", 32'(data), 32'h0);
    check_val("rst_valid", 32'(valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_hit", 32'(addr_hit), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // Plain write to own address
    d_hit = hit_cnt; d_acc = acc_cnt;
    bus_start();
    check_val("t1_busy_started", 32'(busy), 32'd1);
    write_byte({7'h50, 1'b0}, ack);
    check_val("t1_addr_ack", 32'(ack), 32'd0);
    write_byte(8'hA5, ack);
    check_val("t1_data_ack", 32'(ack), 32'd0);
    bus_stop();
    wait_clk(4);
    check_val("t1_hit_pulses", 32'(hit_cnt - d_hit), 32'd1);
    check_val("t1_accepts", 32'(acc_cnt - d_acc), 32'd1);
    check_val("t1_last_data", 32'(last_data), 32'hA5);
    check_val("t1_data_o", 32'(data), 32'hA5);
    check_val("t1_busy_after_stop", 32'(busy), 32'd0);

    // Foreign address: bus never driven
    d_drv = drive_cnt; d_acc = acc_cnt; d_hit = hit_cnt;
    bus_start();
    write_byte({7'h51, 1'b0}, ack);
    check_val("t2_addr_nack", 32'(ack), 32'd1);
    write_byte(8'h3C, ack);
    check_val("t2_data_nack", 32'(ack), 32'd1);
    check_val("t2_busy_wait", 32'(busy), 32'd1);
    bus_stop();
    wait_clk(4);
    check_val("t2_no_drive", 32'(drive_cnt - d_drv), 32'd0);
    check_val("t2_no_valid", 32'(acc_cnt - d_acc), 32'd0);
    check_val("t2_no_hit", 32'(hit_cnt - d_hit), 32'd0);
    check_val("t2_idle", 32'(busy), 32'd0);

    // Read request to own address is not served
    d_hit = hit_cnt; d_drv = drive_cnt;
    bus_start();
    write_byte({7'h50, 1'b1}, ack);
    check_val("t3_addr_nack", 32'(ack), 32'd1);
    check_val("t3_wait_stop_busy", 32'(busy), 32'd1);
    bus_stop();
    wait_clk(4);
    check_val("t3_no_hit", 32'(hit_cnt - d_hit), 32'd0);
    check_val("t3_no_drive", 32'(drive_cnt - d_drv), 32'd0);
    check_val("t3_idle", 32'(busy), 32'd0);

    // Back-pressure: second byte dropped
    ready = 1'b0;
    d_ovf = ovf_cnt; d_acc = acc_cnt;
    bus_start();
    write_byte({7'h50, 1'b0}, ack);
    check_val("t4_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h11, ack);
    check_val("t4_first_ack", 32'(ack), 32'd0);
    write_byte(8'h22, ack);
    check_val("t4_second_nack", 32'(ack), 32'd1);
    bus_stop();
    wait_clk(4);
    check_val("t4_ovf_pulses", 32'(ovf_cnt - d_ovf), 32'd1);
    check_val("t4_valid_held", 32'(valid), 32'd1);
    check_val("t4_data_held", 32'(data), 32'h11);
    ready = 1'b1;
    wait_clk(2);
    check_val("t4_valid_cleared", 32'(valid), 32'd0);
    check_val("t4_accepts", 32'(acc_cnt - d_acc), 32'd1);
    check_val("t4_accepted_data", 32'(last_data), 32'h11);

    // Repeated START after first data byte
    d_hit = hit_cnt; d_acc = acc_cnt;
    bus_start();
    write_byte({7'h50, 1'b0}, ack);
    write_byte(8'h5A, ack);
    check_val("t5_first_byte_ack", 32'(ack), 32'd0);
    bus_rstart();
    check_val("t5_busy_rstart", 32'(busy), 32'd1);
    write_byte({7'h50, 1'b0}, ack);
    check_val("t5_readdr_ack", 32'(ack), 32'd0);
    write_byte(8'h7E, ack);
    check_val("t5_second_byte_ack", 32'(ack), 32'd0);
    bus_stop();
    wait_clk(4);
    check_val("t5_hit_pulses", 32'(hit_cnt - d_hit), 32'd2);
    check_val("t5_accepts", 32'(acc_cnt - d_acc), 32'd2);
    check_val("t5_last_data", 32'(last_data), 32'h7E);

    // Asynchronous reset in the middle of the 4th data bit
    bus_start();
    write_byte({7'h50, 1'b0}, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    sda_m = 1'b0; wait_clk(4);
    scl = 1'b1;   wait_clk(2);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_sda_t", 32'(sda_t), 32'd1);
    check_val("t6_rst_data", 32'(data), 32'h0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_valid", 32'(valid), 32'd0);
    wait_clk(1);
    sda_m = 1'b1; scl = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    d_hit = hit_cnt; d_acc = acc_cnt;
    bus_start();
    write_byte({7'h50, 1'b0}, ack);
    check_val("t6_post_addr_ack", 32'(ack), 32'd0);
    write_byte(8'hC3, ack);
    check_val("t6_post_data_ack", 32'(ack), 32'd0);
    bus_stop();
    wait_clk(4);
    check_val("t6_post_hit", 32'(hit_cnt - d_hit), 32'd1);
    check_val("t6_post_accepts", 32'(acc_cnt - d_acc), 32'd1);
    check_val("t6_post_data", 32'(last_data), 32'hC3);
    check_val("t6_post_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
